// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline latch.
// Issues the dcache request for the instruction in EX/MEM, holds it until
// dhit (raising mem_stall meanwhile), picks the writeback value and latches
// it with wsel/RegWr/halt for the register file.
module mem_wb_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          en,
  input  logic          flush,
  input  logic          dREN_i,
  input  logic          dWEN_i,
  input  logic [DW-1:0] OutputPort_i,
  input  logic [DW-1:0] rdat2_i,
  input  logic [DW-1:0] imm_i,
  input  logic [DW-1:0] pc4_i,
  input  logic [RW-1:0] wsel_i,
  input  logic          RegWr_i,
  input  logic [1:0]    MemToReg_i,
  input  logic          halt_i,
  input  logic          dhit,
  input  logic [DW-1:0] dmemload,
  output logic          dmemREN,
  output logic          dmemWEN,
  output logic [DW-1:0] dmemaddr,
  output logic [DW-1:0] dmemstore,
  output logic          mem_stall,
  output logic [DW-1:0] fwd_dat,
  output logic [DW-1:0] wdat_o,
  output logic [RW-1:0] wsel_o,
  output logic          RegWr_o,
  output logic          halt_o
);

  // SERVED: the access completed while the pipeline was frozen, so the load
  // value sits in lbuf and the request must not be reissued.
  // HALTED: the program has ended; memory traffic is suppressed for good.
  typedef enum logic [1:0] {IDLE, SERVED, HALTED} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] lbuf_q, lbuf_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [RW-1:0] wsel_q, wsel_d;
  logic          regwr_q, regwr_d;
  logic          halt_q, halt_d;

  logic          req;
  logic          adv;
  logic [DW-1:0] ld;

  // Request generation, stall, load-data source and writeback select.
  always_comb begin
    req       = (state_q == IDLE) && (dREN_i || dWEN_i);
    dmemREN   = req && dREN_i;
    dmemWEN   = req && dWEN_i;
    dmemaddr  = OutputPort_i;
    dmemstore = rdat2_i;
    mem_stall = req && !dhit;
    adv       = en && !mem_stall;
    ld        = (state_q == SERVED) ? lbuf_q : dmemload;
    case (MemToReg_i)
      2'b00:   fwd_dat = OutputPort_i;
      2'b01:   fwd_dat = ld;
      2'b10:   fwd_dat = pc4_i;
      default: fwd_dat = imm_i;
    endcase
  end

  // Next-state logic for the FSM, the load buffer and the MEM/WB latch.
  always_comb begin
    state_d = state_q;
    lbuf_d  = lbuf_q;
    wdat_d  = wdat_q;
    wsel_d  = wsel_q;
    regwr_d = regwr_q;
    halt_d  = halt_q;
    if (flush && (state_q != HALTED)) begin
      // Flush beats advance; halt_o is deliberately left untouched.
      wdat_d  = '0;
      wsel_d  = '0;
      regwr_d = 1'b0;
      lbuf_d  = '0;
      state_d = IDLE;
    end else begin
      if (adv) begin
        wdat_d  = fwd_dat;
        wsel_d  = wsel_i;
        regwr_d = RegWr_i;
        halt_d  = halt_q || halt_i;
      end
      case (state_q)
        IDLE: begin
          if (req && dhit && !en) begin
            lbuf_d  = dmemload;
            state_d = SERVED;
          end else if (halt_i && adv) begin
            state_d = HALTED;
          end
        end
        SERVED: begin
          if (en) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      lbuf_q  <= '0;
      wdat_q  <= '0;
      wsel_q  <= '0;
      regwr_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lbuf_q  <= lbuf_d;
      wdat_q  <= wdat_d;
      wsel_q  <= wsel_d;
      regwr_q <= regwr_d;
      halt_q  <= halt_d;
    end
  end

  assign wdat_o  = wdat_q;
  assign wsel_o  = wsel_q;
  assign RegWr_o = regwr_q;
  assign halt_o  = halt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table of single-cycle operations
// followed by hand-written multi-cycle sequences (miss, served, flush, halt).
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        en, flush, dREN_i, dWEN_i, RegWr_i, halt_i, dhit;
  logic [31:0] OutputPort_i, rdat2_i, imm_i, pc4_i, dmemload;
  logic [4:0]  wsel_i;
  logic [1:0]  MemToReg_i;
  logic        dmemREN, dmemWEN, mem_stall, RegWr_o, halt_o;
  logic [31:0] dmemaddr, dmemstore, fwd_dat, wdat_o;
  logic [4:0]  wsel_o;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DW(32), .RW(5)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .dREN_i(dREN_i), .dWEN_i(dWEN_i), .OutputPort_i(OutputPort_i),
    .rdat2_i(rdat2_i), .imm_i(imm_i), .pc4_i(pc4_i), .wsel_i(wsel_i),
    .RegWr_i(RegWr_i), .MemToReg_i(MemToReg_i), .halt_i(halt_i),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .fwd_dat(fwd_dat),
    .wdat_o(wdat_o), .wsel_o(wsel_o), .RegWr_o(RegWr_o), .halt_o(halt_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dren, dwen;
    logic [31:0] addr, rdat2, imm, pc4;
    logic [4:0]  wsel;
    logic        regwr;
    logic [1:0]  m2r;
    logic        halt, hit;
    logic [31:0] load;
    logic        en;
    logic        exp_ren, exp_wen, exp_stall;
    logic [31:0] exp_fwd, exp_wdat;
    logic [4:0]  exp_wsel;
    logic        exp_regwr;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    en = 0; flush = 0; dREN_i = 0; dWEN_i = 0; RegWr_i = 0; halt_i = 0;
    dhit = 0; OutputPort_i = 0; rdat2_i = 0; imm_i = 0; pc4_i = 0;
    dmemload = 0; wsel_i = 0; MemToReg_i = 0;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] wd,
                          input logic [4:0] ws, input logic rw);
    chk({tag, ".wdat_o"}, wdat_o, wd);
    chk({tag, ".wsel_o"}, {27'd0, wsel_o}, {27'd0, ws});
    chk({tag, ".RegWr_o"}, {31'd0, RegWr_o}, {31'd0, rw});
  endtask

  // Inputs change at negedge, combinational outputs are sampled 1 ns later,
  // registered outputs 1 ns after the following posedge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //               dren dwen addr          rdat2   imm           pc4    wsel  rw m2r  hlt hit load          en  ren wen stl fwd           wdat          wsel  rw
    vec[0] = '{1'b1, 1'b0, 32'h100,      32'h0,  32'h0,        32'h0,  5'd8, 1, 2'b01, 0, 1, 32'hDEADBEEF, 1,  1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd8,  1};
    vec[1] = '{1'b0, 1'b0, 32'h0,        32'h0,  32'h0,        32'h44, 5'd31,1, 2'b10, 0, 0, 32'h0,        1,  0, 0, 0, 32'h44,       32'h44,       5'd31, 1};
    vec[2] = '{1'b0, 1'b0, 32'h0,        32'h0,  32'hABCD0000, 32'h0,  5'd5, 1, 2'b11, 0, 0, 32'h0,        1,  0, 0, 0, 32'hABCD0000, 32'hABCD0000, 5'd5,  1};
    vec[3] = '{1'b0, 1'b0, 32'h7,        32'h0,  32'h0,        32'h0,  5'd2, 1, 2'b00, 0, 0, 32'h0,        1,  0, 0, 0, 32'h7,        32'h7,        5'd2,  1};
    vec[4] = '{1'b0, 1'b0, 32'h9,        32'h0,  32'h0,        32'h0,  5'd4, 0, 2'b00, 0, 0, 32'h0,        0,  0, 0, 0, 32'h9,        32'h7,        5'd2,  1};
    vec[5] = '{1'b0, 1'b1, 32'h300,      32'h55, 32'h0,        32'h0,  5'd0, 0, 2'b00, 0, 1, 32'h0,        1,  0, 1, 0, 32'h300,      32'h300,      5'd0,  0};

    clear_inputs();
    #2;
    chk("reset.wdat_o", wdat_o, 32'h0);
    chk("reset.halt_o", {31'd0, halt_o}, 32'h0);
    chk("reset.dmemREN", {31'd0, dmemREN}, 32'h0);
    @(negedge CLK);
    nRST = 1;

    // Table-driven single-cycle operations.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      dREN_i = vec[i].dren; dWEN_i = vec[i].dwen; OutputPort_i = vec[i].addr;
      rdat2_i = vec[i].rdat2; imm_i = vec[i].imm; pc4_i = vec[i].pc4;
      wsel_i = vec[i].wsel; RegWr_i = vec[i].regwr; MemToReg_i = vec[i].m2r;
      halt_i = vec[i].halt; dhit = vec[i].hit; dmemload = vec[i].load; en = vec[i].en;
      #1;
      chk($sformatf("vec%0d.dmemREN", i), {31'd0, dmemREN}, {31'd0, vec[i].exp_ren});
      chk($sformatf("vec%0d.dmemWEN", i), {31'd0, dmemWEN}, {31'd0, vec[i].exp_wen});
      chk($sformatf("vec%0d.mem_stall", i), {31'd0, mem_stall}, {31'd0, vec[i].exp_stall});
      chk($sformatf("vec%0d.dmemaddr", i), dmemaddr, vec[i].addr);
      chk($sformatf("vec%0d.dmemstore", i), dmemstore, vec[i].rdat2);
      chk($sformatf("vec%0d.fwd_dat", i), fwd_dat, vec[i].exp_fwd);
      next_cycle();
      chk_regs($sformatf("vec%0d", i), vec[i].exp_wdat, vec[i].exp_wsel, vec[i].exp_regwr);
      $display("vector %0d: fwd=0x%08h wdat_o=0x%08h wsel_o=%0d", i, fwd_dat, wdat_o, wsel_o);
    end

    // Store miss: three miss cycles then the hit; MEM/WB frozen meanwhile.
    @(negedge CLK);
    clear_inputs();
    dWEN_i = 1; OutputPort_i = 32'h200; rdat2_i = 32'h1234; wsel_i = 5'd9; en = 1;
    for (int c = 0; c < 4; c++) begin
      dhit = (c == 3);
      #1;
      chk($sformatf("miss%0d.dmemWEN", c), {31'd0, dmemWEN}, 32'h1);
      chk($sformatf("miss%0d.dmemaddr", c), dmemaddr, 32'h200);
      chk($sformatf("miss%0d.dmemstore", c), dmemstore, 32'h1234);
      chk($sformatf("miss%0d.mem_stall", c), {31'd0, mem_stall}, (c == 3) ? 32'h0 : 32'h1);
      next_cycle();
      if (c < 3) chk_regs($sformatf("miss%0d", c), 32'h300, 5'd0, 1'b0);
      else       chk_regs("miss_hit", 32'h200, 5'd9, 1'b0);
      $display("store miss cycle %0d: stall=%0b wdat_o=0x%08h", c, mem_stall, wdat_o);
      @(negedge CLK);
    end

    // Hit while frozen: value is buffered, request dropped, captured later.
    clear_inputs();
    dREN_i = 1; OutputPort_i = 32'h40; dhit = 1; dmemload = 32'hCAFE0001;
    MemToReg_i = 2'b01; wsel_i = 5'd10; RegWr_i = 1; en = 0;
    #1;
    chk("served.hit_ren", {31'd0, dmemREN}, 32'h1);
    chk("served.hit_fwd", fwd_dat, 32'hCAFE0001);
    next_cycle();
    chk_regs("served.hold0", 32'h200, 5'd9, 1'b0);
    @(negedge CLK);
    dhit = 0; dmemload = 32'h0;
    #1;
    chk("served.ren", {31'd0, dmemREN}, 32'h0);
    chk("served.stall", {31'd0, mem_stall}, 32'h0);
    chk("served.fwd", fwd_dat, 32'hCAFE0001);
    next_cycle();
    chk_regs("served.hold1", 32'h200, 5'd9, 1'b0);
    @(negedge CLK);
    en = 1;
    next_cycle();
    chk_regs("served.capture", 32'hCAFE0001, 5'd10, 1'b1);
    $display("served load: wdat_o=0x%08h wsel_o=%0d", wdat_o, wsel_o);
    @(negedge CLK);
    #1;
    chk("served.reissue_ren", {31'd0, dmemREN}, 32'h1);
    chk("served.reissue_stall", {31'd0, mem_stall}, 32'h1);

    // Flush during a miss clears MEM/WB; the request reissues afterwards.
    @(negedge CLK);
    clear_inputs();
    OutputPort_i = 32'h11; wsel_i = 5'd3; RegWr_i = 1; en = 1;
    next_cycle();
    chk_regs("flush.pre", 32'h11, 5'd3, 1'b1);
    @(negedge CLK);
    dREN_i = 1; dhit = 0; flush = 1;
    next_cycle();
    chk_regs("flush.post", 32'h0, 5'd0, 1'b0);
    @(negedge CLK);
    flush = 0;
    #1;
    chk("flush.reissue_ren", {31'd0, dmemREN}, 32'h1);
    $display("flush during miss: wdat_o=0x%08h wsel_o=%0d RegWr_o=%0b", wdat_o, wsel_o, RegWr_o);

    // Halt: sticky, suppresses requests, survives flush, cleared by reset.
    @(negedge CLK);
    clear_inputs();
    halt_i = 1; en = 1; OutputPort_i = 32'h22; wsel_i = 5'd1;
    next_cycle();
    chk("halt.set", {31'd0, halt_o}, 32'h1);
    @(negedge CLK);
    halt_i = 0; dREN_i = 1; dhit = 0;
    #1;
    chk("halt.ren", {31'd0, dmemREN}, 32'h0);
    chk("halt.stall", {31'd0, mem_stall}, 32'h0);
    @(negedge CLK);
    flush = 1;
    next_cycle();
    chk("halt.after_flush", {31'd0, halt_o}, 32'h1);
    @(negedge CLK);
    flush = 0;
    #2;
    nRST = 0;
    dREN_i = 0;
    #1;
    chk("halt.async_reset", {31'd0, halt_o}, 32'h0);
    chk("halt.async_reset_wdat", wdat_o, 32'h0);
    @(negedge CLK);
    nRST = 1;
    dREN_i = 1;
    #1;
    chk("halt.after_reset_ren", {31'd0, dmemREN}, 32'h1);
    $display("halt sequence: halt_o=%0b dmemREN=%0b", halt_o, dmemREN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline latch of the 5-stage pipelined MIPS datapath. Sits directly downstream of the EX/MEM latch.
- Issues the data-cache request for the instruction held in EX/MEM and holds it until dhit. Raises mem_stall to the hazard unit while the request is outstanding.
- Selects writeback data and registers it, with wsel, RegWr and halt, into the MEM/WB outputs consumed by the register file.

Parameters:
DW, 32, data/address width
RW, 5, register-select width

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
en  in  1  hazard-unit advance enable for MEM/WB
flush  in  1  synchronous clear of MEM/WB and FSM
dREN_i  in  1  load request from EX/MEM
dWEN_i  in  1  store request from EX/MEM
OutputPort_i  in  DW  ALU result / memory address
rdat2_i  in  DW  store data
imm_i  in  DW  upper-immediate value (already shifted)
pc4_i  in  DW  PC+4 (jal link)
wsel_i  in  RW  destination register
RegWr_i  in  1  register write enable
MemToReg_i  in  2  writeback select: 00 ALU, 01 load, 10 pc4, 11 imm
halt_i  in  1  halt marker
dhit  in  1  dcache access complete (combinational, same cycle)
dmemload  in  DW  dcache read data, valid only with dhit
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  DW  dcache address
dmemstore  out  DW  dcache write data
mem_stall  out  1  request outstanding, pipeline must freeze
fwd_dat  out  DW  combinational MEM-stage writeback value for forwarding
wdat_o  out  DW  registered writeback data
wsel_o  out  RW  registered destination
RegWr_o  out  1  registered write enable
halt_o  out  1  registered sticky halt

Behaviour:
- Reset (async): state=IDLE, load buffer=0, wdat_o/wsel_o/RegWr_o/halt_o=0. A reset mid-miss drops dmemREN/dmemWEN immediately, because state leaves IDLE semantics and upstream inputs reset to 0.
- FSM states: IDLE, SERVED, HALTED.
- req = (state==IDLE) & (dREN_i|dWEN_i).
  - dmemREN = req & dREN_i; dmemWEN = req & dWEN_i.
  - dmemaddr = OutputPort_i; dmemstore = rdat2_i (both are pure pass-through, always driven).
- mem_stall = req & ~dhit. The request stays asserted with stable address/data every cycle until dhit.
- Load data: ld = (state==SERVED) ? load buffer : dmemload.
- fwd_dat is selected by MemToReg_i: 00 OutputPort_i, 01 ld, 10 pc4_i, 11 imm_i.
- adv = en & ~mem_stall.
  - On adv: wdat_o<=fwd_dat, wsel_o<=wsel_i, RegWr_o<=RegWr_i, halt_o<=halt_o|halt_i.
  - Otherwise all MEM/WB outputs hold.
  - en=1 with mem_stall=1 is treated as no advance.
- IDLE transitions:
  - req & dhit & ~en: load buffer<=dmemload, go to SERVED. The access is never reissued.
  - halt_i & adv: go to HALTED.
  - Otherwise stay in IDLE.
- SERVED: no request, mem_stall=0. Go to IDLE on en (after capturing the buffered value) or on flush.
- HALTED: requests suppressed permanently, mem_stall=0. Left only by nRST. halt_o stays 1.
- flush (non-HALTED): wdat_o/wsel_o/RegWr_o<=0, state<=IDLE, load buffer<=0.
  - flush takes priority over adv.
  - flush does not clear halt_o.
  - An outstanding request is abandoned; if EX/MEM still presents a memory op next cycle, it reissues.
- All arithmetic is pure selection; no width conversion. wsel is RW bits, everything else is DW.

Test Plan:
- Load hit: dREN_i=1, OutputPort_i=0x100, dhit=1, dmemload=0xDEADBEEF, MemToReg=01, wsel=8, RegWr=1, en=1 -> dmemREN=1, dmemaddr=0x100, mem_stall=0; next edge wdat_o=0xDEADBEEF, wsel_o=8, RegWr_o=1.
- Store miss: dWEN_i=1, addr 0x200, rdat2=0x1234, dhit low 3 cycles then high, en=1 -> dmemWEN=1/dmemaddr=0x200/dmemstore=0x1234 stable 4 cycles; mem_stall=1 for 3 cycles; MEM/WB holds prior values; captures on the hit cycle.
- Hit with en=0: lw dhit=1, dmemload=0xCAFE0001, en=0 -> SERVED; dmemREN=0 next cycles; dmemload forced to 0; en=1 two cycles later -> wdat_o=0xCAFE0001.
- Writeback select: MemToReg=10, pc4=0x44, wsel=31 -> wdat_o=0x44; MemToReg=11, imm=0xABCD0000 -> wdat_o=0xABCD0000; MemToReg=00, ALU=7 -> wdat_o=7.
- Flush during miss: dREN_i=1, dhit=0, MEM/WB holding wsel_o=3, RegWr_o=1, flush=1 -> next edge wdat_o=0, wsel_o=0, RegWr_o=0, state IDLE.
- Halt: halt_i=1, en=1 -> halt_o=1. Later dREN_i=1 -> dmemREN=0, mem_stall=0. flush leaves halt_o=1. nRST low mid-cycle -> halt_o=0 immediately.
